alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of adder and ALU operands/results.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 func  input  6  instruction function field (bits 5:0 of an R-type instruction).
REQ-005 alu_op  input  3  operation class from the control unit.
REQ-006 operand1  input  WIDTH  ALU first operand (register read data 1).
REQ-007 operand2  input  WIDTH  ALU second operand (read data 2 or sign-extended immediate).
REQ-008 add_a  input  WIDTH  address-adder operand A (PC or PC+4).
REQ-009 add_b  input  WIDTH  address-adder operand B (constant 4 or shifted offset).
REQ-010 alu_sel  output  4  registered ALU selector produced by the control decode.
REQ-011 result  output  WIDTH  registered ALU result.
REQ-012 zf  output  1  registered zero flag: 1 when result is all zeros.
REQ-013 add_sum  output  WIDTH  registered address-adder sum.

Function
REQ-014 Latency: every output SHALL reflect the inputs sampled at the previous rising clk edge (one cycle); no combinational input-to-output path.
REQ-015 Adder: add_sum SHALL be (add_a + add_b) modulo 2^WIDTH; carry discarded, no overflow flag.
REQ-016 Control decode by alu_op: 000 ADD, 001 SUB, 010 decode func, 011 AND, 100 OR, 101 SLT, 110 and 111 ADD.
REQ-017 func decode when alu_op=010: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT; any other func SHALL give ADD.
REQ-018 Selector codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, NOR 1100.
REQ-019 ALU ADD/SUB SHALL wrap modulo 2^WIDTH with no overflow trap.
REQ-020 SLT SHALL compare operand1 < operand2 as signed two's-complement; result 1 (zero-extended) or 0.
REQ-021 AND/OR/XOR/NOR SHALL be bitwise over WIDTH bits.
REQ-022 zf SHALL be computed from the same-cycle ALU result before registering, so zf and result are always consistent.
REQ-023 Selector values outside REQ-018 are unreachable; internally the ALU SHALL map them to result 0.

Reset
REQ-024 While reset=0, alu_sel, result, add_sum SHALL be 0 and zf SHALL be 1, asynchronously and independent of clk.
REQ-025 On reset release, the first rising edge SHALL load values computed from the current inputs; reset asserted mid-operation SHALL discard the pending result immediately.

Structure
REQ-026 A shared package SHALL hold the alu_op encodings, func codes and 4-bit selector constants.
REQ-027 Control decode SHALL be a sub-module alu_control (purely combinational) instantiated inside alu_exec_unit; adder and ALU datapath stay in the top level.

Verification
REQ-028 Reset: reset=0 with arbitrary inputs -> result=0, add_sum=0, alu_sel=0000, zf=1 without a clock edge.
REQ-029 PC increment: add_a=0xFFFFFFFC, add_b=4 -> one cycle later add_sum=0x00000000 (wrap).
REQ-030 Branch compare: alu_op=001, operand1=operand2=0x12345678 -> alu_sel=0110, result=0, zf=1; operand2=0x12345679 -> result=0xFFFFFFFF, zf=0.
REQ-031 R-type sweep: alu_op=010, operand1=0xF0F0F0F0, operand2=0x0FF00FF0; func 100100 -> 0x00F000F0; 100101 -> 0xFFF0FFF0; 100110 -> 0xFF00FF00; 100111 -> 0x000F000F.
REQ-032 Signed SLT: alu_op=010, func=101010, operand1=0xFFFFFFFF, operand2=1 -> result=1, zf=0; swapped operands -> result=0, zf=1.
REQ-033 Default decode: alu_op=010, func=000000, operand1=5, operand2=7 -> alu_sel=0010, result=12; alu_op=111 with same operands -> result=12.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: alu_op classes, R-type func codes and ALU selector constants
package alu_exec_unit_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_FUNC = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_SLT  = 3'b101,
    OP_ADD6 = 3'b110,
    OP_ADD7 = 3'b111
  } alu_op_e;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_XOR = 4'b0011;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_SLT = 4'b0111;
  localparam logic [3:0] SEL_NOR = 4'b1100;
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: operand/opcode inputs and registered results of the execute stage
interface alu_exec_unit_if #(parameter int WIDTH = 32);
  logic [5:0]       func;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] result;
  logic             zf;
  logic [WIDTH-1:0] add_sum;
  modport master (output func, alu_op, operand1, operand2, add_a, add_b,
                  input alu_sel, result, zf, add_sum);
  modport slave (input func, alu_op, operand1, operand2, add_a, add_b,
                 output alu_sel, result, zf, add_sum);
endinterface

// File: rtl/alu_exec_unit_control.sv
// alu_control: combinational decode of alu_op/func into the 4-bit ALU selector
module alu_control
  import alu_exec_unit_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] func,
  output logic [3:0] alu_sel
);
  logic [3:0] func_sel;
  assign func_sel = func == F_SUB ? SEL_SUB :
                    func == F_AND ? SEL_AND :
                    func == F_OR  ? SEL_OR  :
                    func == F_XOR ? SEL_XOR :
                    func == F_NOR ? SEL_NOR :
                    func == F_SLT ? SEL_SLT : SEL_ADD;
  assign alu_sel = alu_op == OP_SUB  ? SEL_SUB  :
                   alu_op == OP_FUNC ? func_sel :
                   alu_op == OP_AND  ? SEL_AND  :
                   alu_op == OP_OR   ? SEL_OR   :
                   alu_op == OP_SLT  ? SEL_SLT  : SEL_ADD;
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: one-cycle registered ALU plus address adder with async active-low reset
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  alu_exec_unit_if.slave bus
);
  logic [3:0]       sel;
  logic [WIDTH-1:0] a, b, alu_y;
  assign a = bus.operand1;
  assign b = bus.operand2;
  alu_control u_ctrl (.alu_op(bus.alu_op), .func(bus.func), .alu_sel(sel));
  always_comb
    alu_y = sel == SEL_AND ? a & b :
            sel == SEL_OR  ? a | b :
            sel == SEL_ADD ? a + b :
            sel == SEL_XOR ? a ^ b :
            sel == SEL_SUB ? a - b :
            sel == SEL_SLT ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} :
            sel == SEL_NOR ? ~(a | b) : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.alu_sel <= '0;
      bus.result  <= '0;
      bus.zf      <= 1'b1;
      bus.add_sum <= '0;
    end else begin
      bus.alu_sel <= sel;
      bus.result  <= alu_y;
      bus.zf      <= alu_y == '0;
      bus.add_sum <= bus.add_a + bus.add_b;
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with hand-computed expectations for alu_exec_unit
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  alu_exec_unit_if #(.WIDTH(32)) bus ();
  alu_exec_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [5:0] f,
                       input logic [31:0] o1, input logic [31:0] o2,
                       input logic [31:0] aa, input logic [31:0] ab);
    bus.alu_op = op; bus.func = f; bus.operand1 = o1; bus.operand2 = o2;
    bus.add_a = aa; bus.add_b = ab;
  endtask

  task automatic expect_all(input string tag, input logic [3:0] sel, input logic [31:0] res,
                            input logic z, input logic [31:0] sum);
    check({tag, ".sel"}, {28'd0, bus.alu_sel}, {28'd0, sel});
    check({tag, ".result"}, bus.result, res);
    check({tag, ".zf"}, {31'd0, bus.zf}, {31'd0, z});
    check({tag, ".add_sum"}, bus.add_sum, sum);
  endtask

  task automatic step(input logic [2:0] op, input logic [5:0] f,
                      input logic [31:0] o1, input logic [31:0] o2,
                      input logic [31:0] aa, input logic [31:0] ab);
    drive(op, f, o1, o2, aa, ab);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(3'b000, 6'd0, 32'd5, 32'd7, 32'd1, 32'd2);
    #7;
    expect_all("pre_reset", 4'b0010, 32'd12, 1'b0, 32'd3);
    reset = 1'b0;
    #1;
    expect_all("async_reset", 4'b0000, 32'd0, 1'b1, 32'd0);
    drive(3'b010, 6'b100110, 32'hDEAD_BEEF, 32'h1234_5678, 32'hAAAA_0000, 32'h5555);
    @(posedge clk);
    #1;
    expect_all("held_reset", 4'b0000, 32'd0, 1'b1, 32'd0);
    reset = 1'b1;
    step(3'b000, 6'd0, 32'd5, 32'd7, 32'hFFFF_FFFC, 32'd4);
    expect_all("pc_wrap", 4'b0010, 32'd12, 1'b0, 32'h0000_0000);
    step(3'b001, 6'd0, 32'h1234_5678, 32'h1234_5678, 32'h100, 32'h20);
    expect_all("beq_equal", 4'b0110, 32'd0, 1'b1, 32'h120);
    drive(3'b001, 6'd0, 32'h1234_5678, 32'h1234_5679, 32'h0, 32'h0);
    #2;
    expect_all("no_comb_path", 4'b0110, 32'd0, 1'b1, 32'h120);
    @(posedge clk);
    #1;
    expect_all("beq_diff", 4'b0110, 32'hFFFF_FFFF, 1'b0, 32'h0);
    step(3'b010, 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd8, 32'd4);
    expect_all("r_and", 4'b0000, 32'h00F0_00F0, 1'b0, 32'd12);
    step(3'b010, 6'b100101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd8, 32'd4);
    expect_all("r_or", 4'b0001, 32'hFFF0_FFF0, 1'b0, 32'd12);
    step(3'b010, 6'b100110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd8, 32'd4);
    expect_all("r_xor", 4'b0011, 32'hFF00_FF00, 1'b0, 32'd12);
    step(3'b010, 6'b100111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd8, 32'd4);
    expect_all("r_nor", 4'b1100, 32'h000F_000F, 1'b0, 32'd12);
    step(3'b010, 6'b100010, 32'd5, 32'd7, 32'd0, 32'd0);
    expect_all("r_sub", 4'b0110, 32'hFFFF_FFFE, 1'b0, 32'd0);
    step(3'b010, 6'b100000, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
    expect_all("r_add_wrap", 4'b0010, 32'h8000_0000, 1'b0, 32'd0);
    step(3'b010, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    expect_all("slt_neg", 4'b0111, 32'd1, 1'b0, 32'd0);
    step(3'b010, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0);
    expect_all("slt_swap", 4'b0111, 32'd0, 1'b1, 32'd0);
    step(3'b010, 6'b000000, 32'd5, 32'd7, 32'd0, 32'd0);
    expect_all("func_default", 4'b0010, 32'd12, 1'b0, 32'd0);
    step(3'b111, 6'b100100, 32'd5, 32'd7, 32'd0, 32'd0);
    expect_all("op_111", 4'b0010, 32'd12, 1'b0, 32'd0);
    step(3'b011, 6'd0, 32'hC, 32'hA, 32'd0, 32'd0);
    expect_all("op_and", 4'b0000, 32'h8, 1'b0, 32'd0);
    step(3'b100, 6'd0, 32'hC, 32'hA, 32'd0, 32'd0);
    expect_all("op_or", 4'b0001, 32'hE, 1'b0, 32'd0);
    step(3'b101, 6'd0, 32'hC, 32'hA, 32'd0, 32'd0);
    expect_all("op_slt", 4'b0111, 32'd0, 1'b1, 32'd0);
    step(3'b110, 6'd0, 32'hC, 32'hA, 32'd0, 32'd0);
    expect_all("op_110", 4'b0010, 32'h16, 1'b0, 32'd0);
    drive(3'b001, 6'd0, 32'd9, 32'd3, 32'd40, 32'd2);
    #2;
    reset = 1'b0;
    #1;
    expect_all("mid_reset", 4'b0000, 32'd0, 1'b1, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    expect_all("after_release", 4'b0110, 32'd6, 1'b0, 32'd42);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
